// File: rtl/reg_oneshot_timed.sv
// Multi-channel one-shot command register with per-channel timeout, one-deep re-arm queue
// and sticky timeout/overrun status. Define ONESHOT_IRQ_EN to add IRQ_MASK / IRQ_Q.
module reg_oneshot_timed #(
  parameter int P_WIDTH   = 4,
  parameter int P_TIMEOUT = 1000,
  parameter int P_GAP     = 2
) (
  input  logic               CLOCK,
  input  logic               RESET_N,
  input  logic               REG_SELECT,
  input  logic               REG_WRITE,
  input  logic [P_WIDTH-1:0] REG_ENA,
  input  logic [P_WIDTH-1:0] DATA_IN,
  input  logic [P_WIDTH-1:0] ACK_IN,
  input  logic [P_WIDTH-1:0] STAT_CLR,
`ifdef ONESHOT_IRQ_EN
  input  logic [P_WIDTH-1:0] IRQ_MASK,
  output logic               IRQ_Q,
`endif
  output logic [P_WIDTH-1:0] DATA_OUT_Q,
  output logic [P_WIDTH-1:0] PENDING_Q,
  output logic [P_WIDTH-1:0] TIMEOUT_Q,
  output logic [P_WIDTH-1:0] OVERRUN_Q
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  localparam int TW = (P_TIMEOUT > 0) ? $clog2(P_TIMEOUT + 1) : 1;
  localparam int GW = $clog2(P_GAP + 1);

  logic [P_WIDTH-1:0] wr;
  assign wr = {P_WIDTH{REG_WRITE & REG_SELECT}} & REG_ENA;

  for (genvar ch = 0; ch < P_WIDTH; ch++) begin : g_ch
    state_t        state;
    logic          act_q, pend_q, tmo_q, ovr_q;
    logic          wr_set, wr_clr, tmo_hit, gap_done;
    logic [GW-1:0] gcnt;

    assign wr_set = wr[ch] & DATA_IN[ch];
    assign wr_clr = wr[ch] & ~DATA_IN[ch];

    // Counters idle at zero outside their state, so every entry starts from a clean count.
    always_ff @(posedge CLOCK) begin
      if (!RESET_N || state != ST_GAP) gcnt <= '0;
      else                             gcnt <= gcnt + GW'(1);
    end
    assign gap_done = (gcnt == GW'(P_GAP - 1));

    if (P_TIMEOUT != 0) begin : g_tmo
      logic [TW-1:0] tcnt;
      always_ff @(posedge CLOCK) begin
        if (!RESET_N || state != ST_ACTIVE) tcnt <= '0;
        else if (tcnt != TW'(P_TIMEOUT))    tcnt <= tcnt + TW'(1);
      end
      assign tmo_hit = (state == ST_ACTIVE) && (tcnt == TW'(P_TIMEOUT - 1));
    end else begin : g_no_tmo
      assign tmo_hit = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; here it also lets a later flag set override the earlier clear.
    always_ff @(posedge CLOCK) begin
      if (!RESET_N) begin
        state  <= ST_IDLE;
        act_q  <= 1'b0;
        pend_q <= 1'b0;
        tmo_q  <= 1'b0;
        ovr_q  <= 1'b0;
      end else begin
        if (STAT_CLR[ch]) begin
          tmo_q <= 1'b0;
          ovr_q <= 1'b0;
        end
        case (state)
          ST_IDLE: begin
            if (!ACK_IN[ch] && wr_set) begin
              state <= ST_ACTIVE;
              act_q <= 1'b1;
            end
          end
          ST_ACTIVE: begin
            if (wr_clr) begin
              state  <= ST_IDLE;
              act_q  <= 1'b0;
              pend_q <= 1'b0;
            end else if (ACK_IN[ch]) begin
              act_q <= 1'b0;
              if (pend_q || wr_set) begin
                state  <= ST_GAP;
                pend_q <= pend_q & wr_set;
              end else begin
                state <= ST_IDLE;
              end
            end else if (tmo_hit) begin
              tmo_q  <= 1'b1;
              act_q  <= 1'b0;
              pend_q <= 1'b0;
              state  <= wr_set ? ST_GAP : ST_IDLE;
            end else if (wr_set) begin
              if (pend_q) ovr_q  <= 1'b1;
              else        pend_q <= 1'b1;
            end
          end
          ST_GAP: begin
            if (wr_clr) begin
              state  <= ST_IDLE;
              pend_q <= 1'b0;
            end else begin
              if (wr_set) begin
                if (pend_q) ovr_q  <= 1'b1;
                else        pend_q <= 1'b1;
              end
              if (gap_done) begin
                state <= ST_ACTIVE;
                act_q <= 1'b1;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            act_q <= 1'b0;
          end
        endcase
      end
    end

    assign DATA_OUT_Q[ch] = act_q;
    assign PENDING_Q[ch]  = pend_q;
    assign TIMEOUT_Q[ch]  = tmo_q;
    assign OVERRUN_Q[ch]  = ovr_q;
  end

`ifdef ONESHOT_IRQ_EN
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) IRQ_Q <= 1'b0;
    else          IRQ_Q <= |((TIMEOUT_Q | OVERRUN_Q) & IRQ_MASK);
  end
`endif

endmodule

// File: tb/tb_reg_oneshot_timed.sv
// Directed bench for reg_oneshot_timed: behavioural per-channel model compared every cycle,
// plus hand-computed expectations at key points.
module tb_reg_oneshot_timed;
  localparam int W   = 4;
  localparam int TMO = 8;
  localparam int GAP = 2;

  logic         CLOCK = 1'b0;
  logic         RESET_N = 1'b0;
  logic         REG_SELECT = 1'b0;
  logic         REG_WRITE = 1'b0;
  logic [W-1:0] REG_ENA = '0;
  logic [W-1:0] DATA_IN = '0;
  logic [W-1:0] ACK_IN = '0;
  logic [W-1:0] STAT_CLR = '0;
  logic [W-1:0] DATA_OUT_Q, PENDING_Q, TIMEOUT_Q, OVERRUN_Q;
`ifdef ONESHOT_IRQ_EN
  logic [W-1:0] IRQ_MASK = 4'b0100;
  logic         IRQ_Q;
  logic         m_irq = 1'b0;
`endif

  reg_oneshot_timed #(.P_WIDTH(W), .P_TIMEOUT(TMO), .P_GAP(GAP)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .REG_SELECT(REG_SELECT), .REG_WRITE(REG_WRITE),
    .REG_ENA(REG_ENA), .DATA_IN(DATA_IN), .ACK_IN(ACK_IN), .STAT_CLR(STAT_CLR),
`ifdef ONESHOT_IRQ_EN
    .IRQ_MASK(IRQ_MASK), .IRQ_Q(IRQ_Q),
`endif
    .DATA_OUT_Q(DATA_OUT_Q), .PENDING_Q(PENDING_Q), .TIMEOUT_Q(TIMEOUT_Q), .OVERRUN_Q(OVERRUN_Q)
  );

  always #5 CLOCK = ~CLOCK;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Model: a channel is either requesting (busy, with its age in cycles), counting down a
  // gap, or idle. Flags are plain bits.
  logic [W-1:0] m_busy = '0, m_pend = '0, m_tmo = '0, m_ovr = '0;
  int           m_age[W];
  int           m_gap[W];

  task automatic model_step();
    logic wr, w1, w0, a, to, ov;
    if (!RESET_N) begin
      m_busy = '0; m_pend = '0; m_tmo = '0; m_ovr = '0;
      for (int i = 0; i < W; i++) begin m_age[i] = 0; m_gap[i] = 0; end
`ifdef ONESHOT_IRQ_EN
      m_irq = 1'b0;
`endif
      return;
    end
`ifdef ONESHOT_IRQ_EN
    m_irq = |((m_tmo | m_ovr) & IRQ_MASK);
`endif
    wr = REG_SELECT & REG_WRITE;
    for (int i = 0; i < W; i++) begin
      w1 = wr & REG_ENA[i] & DATA_IN[i];
      w0 = wr & REG_ENA[i] & ~DATA_IN[i];
      a  = ACK_IN[i];
      to = 1'b0;
      ov = 1'b0;
      if (m_busy[i]) begin
        if (w0) begin
          m_busy[i] = 1'b0; m_pend[i] = 1'b0;
        end else if (a) begin
          m_busy[i] = 1'b0;
          if (m_pend[i] || w1) begin m_gap[i] = GAP; m_pend[i] = m_pend[i] && w1; end
        end else if (TMO != 0 && m_age[i] == TMO) begin
          to = 1'b1; m_busy[i] = 1'b0; m_pend[i] = 1'b0;
          if (w1) m_gap[i] = GAP;
        end else begin
          m_age[i]++;
          if (w1) begin if (m_pend[i]) ov = 1'b1; else m_pend[i] = 1'b1; end
        end
      end else if (m_gap[i] > 0) begin
        if (w0) begin
          m_gap[i] = 0; m_pend[i] = 1'b0;
        end else begin
          if (w1) begin if (m_pend[i]) ov = 1'b1; else m_pend[i] = 1'b1; end
          m_gap[i]--;
          if (m_gap[i] == 0) begin m_busy[i] = 1'b1; m_age[i] = 1; end
        end
      end else if (!a && w1) begin
        m_busy[i] = 1'b1; m_age[i] = 1;
      end
      m_tmo[i] = (m_tmo[i] & ~STAT_CLR[i]) | to;
      m_ovr[i] = (m_ovr[i] & ~STAT_CLR[i]) | ov;
    end
  endtask

  always @(posedge CLOCK) model_step();

  always @(negedge CLOCK) begin
    if (chk_en) begin
      check("model_out",  DATA_OUT_Q, m_busy);
      check("model_pend", PENDING_Q,  m_pend);
      check("model_tmo",  TIMEOUT_Q,  m_tmo);
      check("model_ovr",  OVERRUN_Q,  m_ovr);
`ifdef ONESHOT_IRQ_EN
      check("model_irq", {3'b000, IRQ_Q}, {3'b000, m_irq});
`endif
    end
  end

  task automatic step(input logic [1:0] sw, input logic [W-1:0] ena, input logic [W-1:0] din,
                      input logic [W-1:0] ack, input logic [W-1:0] clr);
    {REG_SELECT, REG_WRITE} = sw;
    REG_ENA = ena; DATA_IN = din; ACK_IN = ack; STAT_CLR = clr;
    @(negedge CLOCK);
  endtask

  task automatic idle(input int n);
    repeat (n) step(2'b00, '0, '0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0;
    @(negedge CLOCK);
    @(negedge CLOCK);
    chk_en = 1'b1;
    check("rst_out",  DATA_OUT_Q, 4'b0000);
    check("rst_pend", PENDING_Q,  4'b0000);
    check("rst_tmo",  TIMEOUT_Q,  4'b0000);
    check("rst_ovr",  OVERRUN_Q,  4'b0000);
    RESET_N = 1'b1;

    // Basic handshake
    step(2'b11, 4'b1111, 4'b0101, 4'b0000, 4'b0000); check("hs_arm",  DATA_OUT_Q, 4'b0101);
    step(2'b00, 4'b0000, 4'b0000, 4'b0001, 4'b0000); check("hs_ack0", DATA_OUT_Q, 4'b0100);
    step(2'b00, 4'b0000, 4'b0000, 4'b0100, 4'b0000); check("hs_ack2", DATA_OUT_Q, 4'b0000);

    // Timeout: high for exactly TMO cycles
    step(2'b11, 4'b0100, 4'b0100, 4'b0000, 4'b0000); check("to_arm", DATA_OUT_Q, 4'b0100);
    for (int k = 1; k < TMO; k++) begin
      idle(1); check("to_hold", DATA_OUT_Q, 4'b0100);
    end
    idle(1);
    check("to_drop", DATA_OUT_Q, 4'b0000);
    check("to_flag", TIMEOUT_Q,  4'b0100);
`ifdef ONESHOT_IRQ_EN
    check("irq_lag", {3'b000, IRQ_Q}, 4'b0000);
    idle(1); check("irq_set", {3'b000, IRQ_Q}, 4'b0001);
`endif
    step(2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0100); check("to_clr", TIMEOUT_Q, 4'b0000);
`ifdef ONESHOT_IRQ_EN
    idle(1); check("irq_clr", {3'b000, IRQ_Q}, 4'b0000);
`endif

    // Re-arm and overrun on bit 1
    step(2'b11, 4'b0010, 4'b0010, 4'b0000, 4'b0000); check("ra_arm",  DATA_OUT_Q, 4'b0010);
    step(2'b11, 4'b0010, 4'b0010, 4'b0000, 4'b0000); check("ra_pend", PENDING_Q,  4'b0010);
    step(2'b11, 4'b0010, 4'b0010, 4'b0000, 4'b0000); check("ra_ovr",  OVERRUN_Q,  4'b0010);
    step(2'b00, 4'b0000, 4'b0000, 4'b0010, 4'b0000); check("ra_gap0", DATA_OUT_Q, 4'b0000);
    check("ra_gap_pend", PENDING_Q, 4'b0000);
    idle(1); check("ra_gap1", DATA_OUT_Q, 4'b0000);
    idle(1); check("ra_rearm", DATA_OUT_Q, 4'b0010);
    step(2'b00, 4'b0000, 4'b0000, 4'b0010, 4'b0000); check("ra_done", DATA_OUT_Q, 4'b0000);
    step(2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0010); check("ra_ovr_clr", OVERRUN_Q, 4'b0000);

    // ACK and write-1 together on an ACTIVE bit -> gap, then re-assert
    step(2'b11, 4'b1000, 4'b1000, 4'b0000, 4'b0000);
    step(2'b11, 4'b1000, 4'b1000, 4'b1000, 4'b0000); check("sim_gap", DATA_OUT_Q, 4'b0000);
    idle(1);
    idle(1); check("sim_rearm", DATA_OUT_Q, 4'b1000);
    step(2'b00, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    // Same on an IDLE bit: ACK wins, write discarded
    step(2'b11, 4'b0001, 4'b0001, 4'b0001, 4'b0000); check("idle_ackwin", DATA_OUT_Q, 4'b0000);
    // Abort with ACK in the same cycle
    step(2'b11, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    step(2'b11, 4'b0001, 4'b0000, 4'b0001, 4'b0000); check("abort_ack", DATA_OUT_Q, 4'b0000);
    check("abort_pend", PENDING_Q, 4'b0000);
    // Write strobe not qualified
    step(2'b01, 4'b1111, 4'b1111, 4'b0000, 4'b0000); check("nosel", DATA_OUT_Q, 4'b0000);
    step(2'b10, 4'b1111, 4'b1111, 4'b0000, 4'b0000); check("nowr",  DATA_OUT_Q, 4'b0000);

    // Level ACK held through the gap: exactly one ACTIVE cycle afterwards
    step(2'b11, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
    step(2'b11, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
    step(2'b00, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    step(2'b00, 4'b0000, 4'b0000, 4'b0010, 4'b0000); check("lvl_gap",  DATA_OUT_Q, 4'b0000);
    step(2'b00, 4'b0000, 4'b0000, 4'b0010, 4'b0000); check("lvl_act",  DATA_OUT_Q, 4'b0010);
    step(2'b00, 4'b0000, 4'b0000, 4'b0010, 4'b0000); check("lvl_done", DATA_OUT_Q, 4'b0000);

    // Timeout with a simultaneous write-1 -> gap, then re-assert
    step(2'b11, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
    idle(TMO - 1);
    step(2'b11, 4'b0100, 4'b0100, 4'b0000, 4'b0000); check("tow_gap", DATA_OUT_Q, 4'b0000);
    check("tow_flag", TIMEOUT_Q, 4'b0100);
    idle(1);
    idle(1); check("tow_rearm", DATA_OUT_Q, 4'b0100);
    step(2'b00, 4'b0000, 4'b0000, 4'b0100, 4'b0100); check("tow_clr", TIMEOUT_Q, 4'b0000);

    // Timeout coincident with STAT_CLR: set wins
    step(2'b11, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
    idle(TMO - 1);
    step(2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0100); check("setwin", TIMEOUT_Q, 4'b0100);
    step(2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0100);

    // Write touching a subset of channels, then a partial abort
    step(2'b11, 4'b0110, 4'b1111, 4'b0000, 4'b0000); check("sub_arm",   DATA_OUT_Q, 4'b0110);
    step(2'b11, 4'b0010, 4'b0000, 4'b0000, 4'b0000); check("sub_abort", DATA_OUT_Q, 4'b0100);
    step(2'b00, 4'b0000, 4'b0000, 4'b0100, 4'b0000);

    // Reset during a gap with a sticky flag set: no re-assertion afterwards
    step(2'b11, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
    step(2'b11, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
    step(2'b11, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
    step(2'b00, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    RESET_N = 1'b0;
    idle(1);
    check("mrst_out", DATA_OUT_Q, 4'b0000);
    check("mrst_ovr", OVERRUN_Q,  4'b0000);
    RESET_N = 1'b1;
    idle(3); check("mrst_quiet", DATA_OUT_Q, 4'b0000);

    // Reset pulse between edges has no asynchronous effect
    step(2'b11, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    #1 RESET_N = 1'b0;
    #2 check("glitch_now", DATA_OUT_Q, 4'b0001);
    RESET_N = 1'b1;
    @(negedge CLOCK); check("glitch_after", DATA_OUT_Q, 4'b0001);
    step(2'b00, 4'b0000, 4'b0000, 4'b0001, 4'b0000); check("glitch_ack", DATA_OUT_Q, 4'b0000);

    idle(2);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
